// File: rtl/rf_wb_scheduler.sv
// Writeback scheduler for the 2-bank register file: steers two lanes into
// per-bank queues, drains one write per bank per cycle, forwards queued data.
module rf_wb_scheduler #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter bit DROP_R0 = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            in_valid_i,
    input  logic [1:0][4:0]       in_addr_i,
    input  logic [1:0][WIDTH-1:0] in_data_i,
    output logic                  in_ready_o,
    output logic [4:0]            wa0_o,
    output logic [4:0]            wa1_o,
    output logic [WIDTH-1:0]      wd0_o,
    output logic [WIDTH-1:0]      wd1_o,
    output logic                  we0_o,
    output logic                  we1_o,
    input  logic [3:0][4:0]       ra_i,
    output logic [3:0]            fwd_hit_o,
    output logic [3:0][WIDTH-1:0] fwd_data_o,
    output logic                  busy_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]       q_addr [2][DEPTH];
    logic [WIDTH-1:0] q_data [2][DEPTH];
    logic [PW-1:0]    rd_ptr [2];
    logic [PW-1:0]    wr_ptr [2];
    logic [CW-1:0]    cnt    [2];

    logic [1:0]       acc;
    logic [1:0]       push   [2];
    logic [CW-1:0]    npush  [2];
    logic [1:0]       pop;

    // Ready needs two free slots in both banks so a dual push never overflows.
    assign in_ready_o = rst_n
                     && (cnt[0] <= CW'(DEPTH - 2))
                     && (cnt[1] <= CW'(DEPTH - 2));

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            acc[k] = in_valid_i[k] && in_ready_o
                  && !(DROP_R0 && (in_addr_i[k] == 5'd0));
        end
        push[0][0] = acc[0] && !in_addr_i[0][0];
        push[0][1] = acc[1] && !in_addr_i[1][0];
        push[1][0] = acc[0] &&  in_addr_i[0][0];
        push[1][1] = acc[1] &&  in_addr_i[1][0];
        for (int b = 0; b < 2; b++) begin
            npush[b] = CW'(push[b][0]) + CW'(push[b][1]);
            pop[b]   = (cnt[b] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                rd_ptr[b] <= '0;
                wr_ptr[b] <= '0;
                cnt[b]    <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                wr_ptr[b] <= wr_ptr[b] + PW'(npush[b]);
                rd_ptr[b] <= rd_ptr[b] + PW'(pop[b]);
                cnt[b]    <= cnt[b] + npush[b] - CW'(pop[b]);
            end
        end
    end

    // Lane 0 is older, so it takes the first free slot when both hit one bank.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (push[b][0]) begin
                q_addr[b][wr_ptr[b]] <= in_addr_i[0];
                q_data[b][wr_ptr[b]] <= in_data_i[0];
            end
            if (push[b][1]) begin
                q_addr[b][wr_ptr[b] + PW'(push[b][0])] <= in_addr_i[1];
                q_data[b][wr_ptr[b] + PW'(push[b][0])] <= in_data_i[1];
            end
        end
    end

    assign we0_o  = pop[0];
    assign we1_o  = pop[1];
    assign wa0_o  = pop[0] ? q_addr[0][rd_ptr[0]] : 5'd0;
    assign wa1_o  = pop[1] ? q_addr[1][rd_ptr[1]] : 5'd0;
    assign wd0_o  = pop[0] ? q_data[0][rd_ptr[0]] : '0;
    assign wd1_o  = pop[1] ? q_data[1][rd_ptr[1]] : '0;
    assign busy_o = pop[0] | pop[1];

    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        fwd_hit_o  = '0;
        fwd_data_o = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                logic          bk;
                logic [PW-1:0] idx;
                bk  = ra_i[i][0];
                idx = rd_ptr[bk] + PW'(j);
                if ((CW'(j) < cnt[bk])
                    && (q_addr[bk][idx] == ra_i[i])
                    && !(DROP_R0 && (ra_i[i] == 5'd0))) begin
                    fwd_hit_o[i]  = 1'b1;
                    fwd_data_o[i] = q_data[bk][idx];
                end
            end
        end
    end

endmodule
